// File: rtl/reg_incr_out_queue_if.sv
// Handshake bundle between the incrementer, the output queue and its consumer.
// The slave modport is the queue; the master modport is whoever drives and drains it.
interface reg_incr_out_queue_if #(
    parameter int NBITS    = 8,
    parameter int NENTRIES = 4,
    parameter int DROPBITS = 8
);
    localparam int CW = $clog2(NENTRIES) + 1;

    logic [NBITS-1:0]    in_;
    logic                in_val;
    logic                in_rdy;
    logic [NBITS-1:0]    out;
    logic                out_val;
    logic                out_rdy;
    logic [CW-1:0]       count;
    logic [DROPBITS-1:0] drop_count;
    logic                overflow;

    modport slave (
        input  in_, in_val, out_rdy,
        output in_rdy, out, out_val, count, drop_count, overflow
    );

    modport master (
        output in_, in_val, out_rdy,
        input  in_rdy, out, out_val, count, drop_count, overflow
    );
endinterface

// File: rtl/reg_incr_out_queue.sv
// Small FIFO behind the registered incrementer; the upstream cannot stall, so
// results presented while full are counted (saturating) and flagged as overflow.
module reg_incr_out_queue #(
    parameter int NBITS    = 8,
    parameter int NENTRIES = 4,
    parameter int DROPBITS = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    reg_incr_out_queue_if.slave     bus
);
    localparam int PW = $clog2(NENTRIES);
    localparam int CW = PW + 1;

    logic [NBITS-1:0]    storage_q [NENTRIES];
    logic [PW-1:0]       head_q, head_d;
    logic [PW-1:0]       tail_q, tail_d;
    logic [CW-1:0]       count_q, count_d;
    logic [DROPBITS-1:0] drop_q, drop_d;
    logic                ovf_q, ovf_d;
    logic                enq, deq, drop;

    // in_rdy/out_val/out depend only on registered state: no in_ -> out path.
    assign bus.in_rdy     = (count_q != CW'(NENTRIES));
    assign bus.out_val    = (count_q != '0);
    assign bus.out        = bus.out_val ? storage_q[head_q] : '0;
    assign bus.count      = count_q;
    assign bus.drop_count = drop_q;
    assign bus.overflow   = ovf_q;

    assign enq  = bus.in_val & bus.in_rdy;
    assign deq  = bus.out_val & bus.out_rdy;
    assign drop = bus.in_val & ~bus.in_rdy;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        drop_d  = drop_q;
        ovf_d   = ovf_q;
        if (enq) tail_d = tail_q + 1'b1;
        if (deq) head_d = head_q + 1'b1;
        if (enq && !deq)      count_d = count_q + 1'b1;
        else if (deq && !enq) count_d = count_q - 1'b1;
        if (drop) begin
            ovf_d = 1'b1;
            if (drop_q != '1) drop_d = drop_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            drop_q  <= '0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < NENTRIES; i++) storage_q[i] <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            drop_q  <= drop_d;
            ovf_q   <= ovf_d;
            if (enq) storage_q[tail_q] <= bus.in_;
        end
    end
endmodule

// File: tb/tb_reg_incr_out_queue.sv
// Directed bench for reg_incr_out_queue: fill/drain, full drops, wrap,
// drop-counter saturation and asynchronous mid-stream reset.
module tb_reg_incr_out_queue;
    logic clk;
    logic reset;
    int   errs;
    int   checks;

    reg_incr_out_queue_if #(.NBITS(8), .NENTRIES(4), .DROPBITS(8)) bus ();

    reg_incr_out_queue #(.NBITS(8), .NENTRIES(4), .DROPBITS(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Inputs are changed 1ns after the edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".count"}, bus.count, 0);
        chk({tag, ".out_val"}, bus.out_val, 0);
        chk({tag, ".in_rdy"}, bus.in_rdy, 1);
        chk({tag, ".out"}, bus.out, 0);
        chk({tag, ".drop"}, bus.drop_count, 0);
        chk({tag, ".ovf"}, bus.overflow, 0);
    endtask

    logic [7:0] stream [4];

    initial begin
        errs = 0;
        checks = 0;
        reset = 1'b1;
        bus.in_ = '0;
        bus.in_val = 1'b0;
        bus.out_rdy = 1'b0;
        #22;
        reset = 1'b0;
        tick();
        chk_reset_state("idle");

        // enqueue 01,02,03 with consumer stalled
        bus.in_val = 1'b1;
        bus.in_ = 8'h01; tick();
        chk("enq1.out", bus.out, 8'h01);
        chk("enq1.val", bus.out_val, 1);
        chk("enq1.count", bus.count, 1);
        bus.in_ = 8'h02; tick();
        bus.in_ = 8'h03; tick();
        bus.in_val = 1'b0;
        chk("enq3.count", bus.count, 3);
        chk("enq3.out", bus.out, 8'h01);
        bus.out_rdy = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            chk($sformatf("drain%0d.out", i), bus.out, i);
            chk($sformatf("drain%0d.val", i), bus.out_val, 1);
            tick();
        end
        chk("drained.val", bus.out_val, 0);
        chk("drained.count", bus.count, 0);
        chk("drained.out", bus.out, 0);

        // fill 10..13, then offer 14 three times while full
        bus.out_rdy = 1'b0;
        bus.in_val = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_ = 8'h10 + 8'(i);
            tick();
        end
        chk("full.in_rdy", bus.in_rdy, 0);
        chk("full.count", bus.count, 4);
        bus.in_ = 8'h14;
        tick(); tick(); tick();
        chk("full.drop", bus.drop_count, 3);
        chk("full.ovf", bus.overflow, 1);
        chk("full.count2", bus.count, 4);
        bus.in_val = 1'b0;
        bus.out_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("fdrain%0d.out", i), bus.out, 8'h10 + i);
            tick();
        end
        chk("fdrain.val", bus.out_val, 0);
        chk("fdrain.ovf_held", bus.overflow, 1);

        // steady stream through wrapping pointers
        stream[0] = 8'hFE; stream[1] = 8'hFF; stream[2] = 8'h00; stream[3] = 8'h01;
        bus.in_val = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_ = stream[i];
            tick();
            chk($sformatf("stream%0d.out", i), bus.out, stream[i]);
            chk($sformatf("stream%0d.count", i), bus.count, 1);
        end
        bus.in_val = 1'b0;
        tick();
        chk("stream.empty", bus.count, 0);

        // 300 cycles stalled: 4 enq + 296 drops, counter already at 3 -> saturate
        bus.out_rdy = 1'b0;
        bus.in_val = 1'b1;
        bus.in_ = 8'hAA;
        for (int i = 0; i < 300; i++) tick();
        chk("sat.drop", bus.drop_count, 8'hFF);
        chk("sat.ovf", bus.overflow, 1);
        chk("sat.count", bus.count, 4);

        // drain two so count=2, then reset asynchronously between edges
        bus.in_val = 1'b0;
        bus.out_rdy = 1'b1;
        tick(); tick();
        chk("pre_rst.count", bus.count, 2);
        bus.out_rdy = 1'b0;
        bus.in_val = 1'b1;
        bus.in_ = 8'h77;
        #2;
        reset = 1'b1;
        #1;
        chk_reset_state("async_rst");
        #1;
        reset = 1'b0;
        bus.in_ = 8'h55;
        tick();
        chk("post_rst.out", bus.out, 8'h55);
        chk("post_rst.count", bus.count, 1);
        chk("post_rst.drop", bus.drop_count, 0);
        bus.in_val = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
